pulse_train_gen: RTL and testbench
==================================

Name: pulse_train_gen

Overview:
Generates a burst of N clean, evenly spaced clock pulses on command, with a programmable half-period. It is the transmit side of the positive-edge detection path. Downstream logic, or the panel's source/gate driver clock pins, sees exactly N rising edges per burst. Used by the e-paper line sequencer to clock source-driver data (CL) and gate-driver shifts (CKV) per line.

Parameters:
CNT_W, 16, width of pulse_count and pulses_sent
DIV_W, 8, width of half_period (cycles per high or low phase)

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  burst request; sampled only when busy=0
pulse_count  input  CNT_W  number of pulses in burst; latched on accepted start
half_period  input  DIV_W  cycles per phase; latched on accepted start; 0 treated as 1
pulse_out  output  1  generated pulse train
busy  output  1  high from cycle after accepted start until cycle done asserts
done  output  1  one-cycle strobe at burst end
pulses_sent  output  CNT_W  rising edges emitted in current/last burst

Behaviour:
- Reset (async, any time, including mid-burst): pulse_out=0, busy=0, done=0, pulses_sent=0, state=IDLE, latched regs=0. No partial pulse survives; pulse_out drops immediately.
- States: IDLE, HIGH, LOW, FINISH.
- IDLE:
  - start=1 → latch pulse_count to cnt_q, half_period to hp_q (0→1); clear pulses_sent; busy=1 next cycle.
  - If latched count ≠0 → HIGH, and pulse_out rises the cycle after start (1-cycle latency).
  - If latched count=0 → FINISH directly; no pulses emitted.
- HIGH: pulse_out=1 for exactly hp_q cycles. pulses_sent increments on the cycle pulse_out rises. After hp_q cycles → LOW.
- LOW: pulse_out=0 for exactly hp_q cycles. After hp_q cycles:
  - pulses_sent==cnt_q → FINISH
  - otherwise → HIGH
- FINISH: done=1 for one cycle, busy=0 in the same cycle, then IDLE. pulses_sent holds its final value until the next accepted start.
- Total burst length from start to done = 2·hp_q·N + 1 cycles for N>0, and 1 cycle for N=0. Period = 2·hp_q, duty 50%.
- start while busy=1, or in the FINISH cycle: ignored; no queueing.
- start held high continuously: a new burst is accepted in the first IDLE cycle after FINISH. Back-to-back bursts are therefore separated by at least one low IDLE cycle.
- Input changes to pulse_count/half_period during a burst have no effect.
- Phase counter is DIV_W bits, counts 1..hp_q, and never wraps. pulse_count = 2^CNT_W−1 is legal; pulses_sent never wraps within a burst.
- pulse_out is registered and glitch-free.

Optional Feature:
Macro PULSE_TRAIN_ABORT_EN.
- Defined: adds input abort (1 bit).
  - abort=1 while busy → next cycle pulse_out=0, busy=0, state=IDLE.
  - done is NOT asserted; pulses_sent holds the count at abort.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle → start is accepted, abort ignored.
- Undefined: no abort port. A burst always runs to completion or reset.

Test Plan:
- Reset mid-HIGH phase of a 10-pulse burst → pulse_out=0, busy=0, pulses_sent=0 immediately. A subsequent start with count=2, hp=1 produces exactly 2 pulses.
- start, count=3, hp=2 → pulse_out pattern 1100 1100 1100 starting 1 cycle after start; done at cycle 13 after start; pulses_sent=3; busy high 12 cycles.
- start, count=0, hp=5 → no pulse_out activity; done one cycle after start; pulses_sent=0.
- start, count=2, hp=0 → behaves as hp=1: pattern 1010; done 5 cycles after start.
- start re-pulsed mid-burst with count=7, and pulse_count changed to 7 during a count=4 burst → exactly 4 pulses, single done. start held high → second burst begins 1 IDLE cycle after done.
- With PULSE_TRAIN_ABORT_EN: count=5, hp=3, abort asserted during the 3rd HIGH phase → pulse_out low next cycle, no done, pulses_sent=3, busy=0.

Source files
------------

// File: rtl/pulse_train_gen.sv
// Burst pulse generator: N evenly spaced pulses with programmable half-period.
// Optional abort input enabled by defining PULSE_TRAIN_ABORT_EN.
module pulse_train_gen #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
`ifdef PULSE_TRAIN_ABORT_EN
    input  logic             abort,
`endif
    input  logic [CNT_W-1:0] pulse_count,
    input  logic [DIV_W-1:0] half_period,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulses_sent
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HIGH   = 2'd1,
        LOW    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt_q;
    logic [DIV_W-1:0] hp_q;
    logic [DIV_W-1:0] ph;

    // Zero half-period is clamped to one cycle per phase.
    logic [DIV_W-1:0] hp_eff;
    assign hp_eff = (half_period == '0) ? DIV_W'(1) : half_period;

    // Burst sequencer with registered pulse/status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt_q       <= '0;
            hp_q        <= '0;
            ph          <= '0;
            pulse_out   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pulses_sent <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt_q <= pulse_count;
                        hp_q  <= hp_eff;
                        ph    <= DIV_W'(1);
                        if (pulse_count != '0) begin
                            state       <= HIGH;
                            pulse_out   <= 1'b1;
                            busy        <= 1'b1;
                            pulses_sent <= CNT_W'(1);
                        end else begin
                            state       <= FINISH;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            pulses_sent <= '0;
                        end
                    end
                end
                HIGH: begin
                    if (ph == hp_q) begin
                        state     <= LOW;
                        pulse_out <= 1'b0;
                        ph        <= DIV_W'(1);
                    end else begin
                        ph <= ph + DIV_W'(1);
                    end
                end
                LOW: begin
                    if (ph == hp_q) begin
                        ph <= DIV_W'(1);
                        if (pulses_sent == cnt_q) begin
                            state <= FINISH;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state       <= HIGH;
                            pulse_out   <= 1'b1;
                            pulses_sent <= pulses_sent + CNT_W'(1);
                        end
                    end else begin
                        ph <= ph + DIV_W'(1);
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    pulse_out <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
`ifdef PULSE_TRAIN_ABORT_EN
            // Abort cuts a running burst short without a done strobe.
            if (abort && busy) begin
                state     <= IDLE;
                pulse_out <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b0;
                ph        <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: directed and random bursts
// compared cycle by cycle against a waveform model of the burst timing.
module tb_pulse_train_gen;

    localparam int CNT_W = 16;
    localparam int DIV_W = 8;

    logic             clock;
    logic             reset;
    logic             start;
`ifdef PULSE_TRAIN_ABORT_EN
    logic             abort;
`endif
    logic [CNT_W-1:0] pulse_count;
    logic [DIV_W-1:0] half_period;
    logic             pulse_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulses_sent;

    int vectors;
    int miscompares;

    pulse_train_gen #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
`ifdef PULSE_TRAIN_ABORT_EN
        .abort       (abort),
`endif
        .pulse_count (pulse_count),
        .half_period (half_period),
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done),
        .pulses_sent (pulses_sent)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int p, input int b,
                           input int d, input int s);
        chk({tag, ".pulse_out"}, int'(pulse_out), p);
        chk({tag, ".busy"}, int'(busy), b);
        chk({tag, ".done"}, int'(done), d);
        chk({tag, ".pulses_sent"}, int'(pulses_sent), s);
    endtask

    // Issue one burst and check every cycle against the ideal waveform.
    // hold keeps start high throughout; disturb re-pulses start and
    // alters the inputs mid-burst, which must have no effect.
    task automatic run_burst(input string tag, input int n, input int hp,
                             input bit hold, input bit disturb);
        int h;
        int len;
        int ph;
        h   = (hp == 0) ? 1 : hp;
        len = (n == 0) ? 1 : 2 * h * n + 1;
        start       = 1'b1;
        pulse_count = CNT_W'(n);
        half_period = DIV_W'(hp);
        tick();
        if (!hold) start = 1'b0;
        for (int k = 1; k <= len; k++) begin
            if (disturb && k == 3) begin
                start       = 1'b1;
                pulse_count = CNT_W'(7);
                half_period = DIV_W'(1);
            end
            if (disturb && k == 4) start = 1'b0;
            if (k == len) begin
                chk_all({tag, ".end"}, 0, 0, 1, n);
            end else begin
                ph = (k - 1) % (2 * h);
                chk_all(tag, (ph < h) ? 1 : 0, 1, 0, (k - 1) / (2 * h) + 1);
            end
            tick();
        end
        chk_all({tag, ".idle"}, 0, 0, 0, n);
    endtask

    initial begin
        int n;
        int hp;
        vectors     = 0;
        miscompares = 0;
        start       = 1'b0;
        pulse_count = '0;
        half_period = '0;
`ifdef PULSE_TRAIN_ABORT_EN
        abort       = 1'b0;
`endif
        reset = 1'b1;
        #2;
        chk_all("reset", 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk_all("post_reset", 0, 0, 0, 0);

        // Reset in the middle of a HIGH phase drops everything at once.
        start       = 1'b1;
        pulse_count = CNT_W'(10);
        half_period = DIV_W'(3);
        tick();
        start = 1'b0;
        tick();
        chk_all("pre_rst", 1, 1, 0, 1);
        #2;
        reset = 1'b1;
        #1;
        chk_all("mid_rst", 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        tick();
        chk_all("after_rst", 0, 0, 0, 0);
        run_burst("rst_then_2x1", 2, 1, 1'b0, 1'b0);

        run_burst("n3_hp2", 3, 2, 1'b0, 1'b0);
        tick();
        run_burst("n0_hp5", 0, 5, 1'b0, 1'b0);
        tick();
        run_burst("n2_hp0", 2, 0, 1'b0, 1'b0);
        tick();
        run_burst("disturb_n4", 4, 2, 1'b0, 1'b1);
        tick();
        // Held start: second burst accepted in the single IDLE cycle.
        run_burst("hold_a", 2, 2, 1'b1, 1'b0);
        run_burst("hold_b", 3, 1, 1'b0, 1'b0);
        tick();
        run_burst("n1_hp255", 1, 255, 1'b0, 1'b0);
        tick();

        for (int i = 0; i < 12; i++) begin
            n  = int'($urandom_range(0, 6));
            hp = int'($urandom_range(0, 4));
            run_burst("rand", n, hp, 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end

`ifdef PULSE_TRAIN_ABORT_EN
        // Abort during the third HIGH phase (cycles 13..15 for hp=3).
        start       = 1'b1;
        pulse_count = CNT_W'(5);
        half_period = DIV_W'(3);
        tick();
        start = 1'b0;
        repeat (13) tick();
        chk_all("pre_abort", 1, 1, 0, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_all("abort", 0, 0, 0, 3);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk_all("post_abort", 0, 0, 0, 3);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_all("abort_idle", 0, 0, 0, 3);
        start = 1'b1;
        abort = 1'b1;
        pulse_count = CNT_W'(1);
        half_period = DIV_W'(1);
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk_all("abort_start", 1, 1, 0, 1);
        repeat (4) tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
